// File: rtl/rv32i_types.sv
// Shared RV32I core types: MDU opcode encodings and reservation-station entry layout.
package rv32i_types;

    localparam int XLEN         = 32;
    localparam int RV_TAG_W     = 6;
    localparam int RV_ROB_PTR_W = 4;
    localparam int RV_MDU_OPC_W = 3;

    typedef enum logic [RV_MDU_OPC_W-1:0] {
        mdu_op_mul    = 3'd0,
        mdu_op_mulh   = 3'd1,
        mdu_op_mulhsu = 3'd2,
        mdu_op_mulhu  = 3'd3,
        mdu_op_div    = 3'd4,
        mdu_op_divu   = 3'd5,
        mdu_op_rem    = 3'd6,
        mdu_op_remu   = 3'd7
    } mdu_op_t;

    typedef struct packed {
        logic                rdy;
        logic [RV_TAG_W-1:0] tag;
        logic [XLEN-1:0]     data;
    } rsv_src_t;

    typedef struct packed {
        logic                    valid;
        logic [RV_MDU_OPC_W-1:0] opc;
        logic [RV_TAG_W-1:0]     tag;
        logic [RV_ROB_PTR_W-1:0] inst_id;
        rsv_src_t                src1;
        rsv_src_t                src2;
    } mdu_rsv_entry_t;

    // CDB snoop for one source: tag 0 is the hardwired x0 and never wakes anything.
    function automatic rsv_src_t rsv_wake(input rsv_src_t s, input logic cdb_v,
                                          input logic [RV_TAG_W-1:0] cdb_t,
                                          input logic [XLEN-1:0] cdb_d);
        rsv_src_t r;
        r = s;
        if (cdb_v && (cdb_t != '0) && (cdb_t == s.tag) && !s.rdy) begin
            r.rdy  = 1'b1;
            r.data = cdb_d;
        end
        return r;
    endfunction

endpackage

// File: rtl/mdu_rsv_select.sv
// Lowest-index-ready priority encoder; index 0 is the oldest station entry.
module mdu_rsv_select
    import rv32i_types::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_ready,
    output logic [N-1:0]     o_onehot,
    output logic [IDX_W-1:0] o_idx
);

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_ready[i]) begin
                o_onehot    = '0;
                o_onehot[i] = 1'b1;
                o_idx       = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/mdu_rsv_station.sv
// Collapsing reservation station for the MDU: CDB operand capture, oldest-ready issue.
module mdu_rsv_station
    import rv32i_types::*;
#(
    parameter int DEPTH     = 4,
    parameter int TAG_W     = RV_TAG_W,
    parameter int ROB_PTR_W = RV_ROB_PTR_W,
    parameter int OPC_W     = RV_MDU_OPC_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 disp_req,
    output logic                 disp_rdy,
    input  logic [OPC_W-1:0]     disp_opc,
    input  logic [TAG_W-1:0]     disp_tag,
    input  logic [ROB_PTR_W-1:0] disp_inst_id,
    input  logic                 disp_src1_rdy,
    input  logic                 disp_src2_rdy,
    input  logic [31:0]          disp_src1,
    input  logic [31:0]          disp_src2,
    input  logic [TAG_W-1:0]     disp_src1_tag,
    input  logic [TAG_W-1:0]     disp_src2_tag,
    input  logic                 cdb_valid,
    input  logic [TAG_W-1:0]     cdb_tag,
    input  logic [31:0]          cdb_wdata,
    output logic                 iss_req,
    input  logic                 iss_rdy,
    output logic [OPC_W-1:0]     iss_opc,
    output logic [31:0]          iss_src1,
    output logic [31:0]          iss_src2,
    output logic [TAG_W-1:0]     iss_tag,
    output logic [ROB_PTR_W-1:0] iss_inst_id
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    mdu_rsv_entry_t   r_ent [DEPTH];
    logic [CNT_W-1:0] r_count;

    mdu_rsv_entry_t   w_next [DEPTH];
    mdu_rsv_entry_t   w_new;
    logic [DEPTH-1:0] w_ready;
    logic [DEPTH-1:0] w_sel_oh;
    logic [IDX_W-1:0] w_sel_idx;
    logic             w_sel_vld;
    logic             w_issue;
    logic             w_disp;
    logic [CNT_W-1:0] w_wr_pos;

    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            w_ready[i] = r_ent[i].valid & r_ent[i].src1.rdy & r_ent[i].src2.rdy;
    end

    mdu_rsv_select #(.N(DEPTH), .IDX_W(IDX_W)) u_select (
        .i_ready  (w_ready),
        .o_onehot (w_sel_oh),
        .o_idx    (w_sel_idx)
    );

    always_comb begin
        w_sel_vld   = 1'b0;
        iss_opc     = '0;
        iss_src1    = '0;
        iss_src2    = '0;
        iss_tag     = '0;
        iss_inst_id = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_sel_oh[i]) begin
                w_sel_vld   = r_ent[i].valid;
                iss_opc     = r_ent[i].opc;
                iss_src1    = r_ent[i].src1.data;
                iss_src2    = r_ent[i].src2.data;
                iss_tag     = r_ent[i].tag;
                iss_inst_id = r_ent[i].inst_id;
            end
        end
    end

    assign iss_req  = w_sel_vld & ~flush;
    assign disp_rdy = (r_count != CNT_W'(DEPTH)) & ~flush;
    assign w_issue  = iss_req & iss_rdy;
    assign w_disp   = disp_req & disp_rdy;
    assign w_wr_pos = r_count - CNT_W'(w_issue);

    always_comb begin
        w_new           = '0;
        w_new.valid     = 1'b1;
        w_new.opc       = disp_opc;
        w_new.tag       = disp_tag;
        w_new.inst_id   = disp_inst_id;
        w_new.src1.rdy  = disp_src1_rdy;
        w_new.src1.tag  = disp_src1_tag;
        w_new.src1.data = disp_src1;
        w_new.src2.rdy  = disp_src2_rdy;
        w_new.src2.tag  = disp_src2_tag;
        w_new.src2.data = disp_src2;
        w_new.src1      = rsv_wake(w_new.src1, cdb_valid, cdb_tag, cdb_wdata);
        w_new.src2      = rsv_wake(w_new.src2, cdb_valid, cdb_tag, cdb_wdata);
    end

    // Collapse first, then wake, so a capture follows its entry to the new slot.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_next[i] = r_ent[i];
            if (w_issue && (IDX_W'(i) >= w_sel_idx)) begin
                w_next[i] = r_ent[(i + 1) % DEPTH];
                if (i == DEPTH - 1)
                    w_next[i].valid = 1'b0;
            end
            w_next[i].src1 = rsv_wake(w_next[i].src1, cdb_valid, cdb_tag, cdb_wdata);
            w_next[i].src2 = rsv_wake(w_next[i].src2, cdb_valid, cdb_tag, cdb_wdata);
            if (w_disp && (CNT_W'(i) == w_wr_pos))
                w_next[i] = w_new;
        end
    end

    // NOTE: only valid bits are reset; payload is don't-care while its entry is invalid.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++)
                r_ent[i].valid <= 1'b0;
        end else begin
            r_count <= r_count + CNT_W'(w_disp) - CNT_W'(w_issue);
            r_ent   <= w_next;
        end
    end

endmodule

// File: doc/mdu_rsv_station.md
Name: mdu_rsv_station

Overview:
- Reservation station dedicated to the multiply/divide unit. It sits between dispatch/rename (upstream) and the MDU (downstream).
- Holds up to DEPTH MDU micro-ops and snoops the CDB to capture source operands as they are produced.
- Issues the oldest fully-ready entry to the MDU over the standard req/rdy issue handshake.
- Collapsing queue: entry 0 is always the oldest.

Parameters:
DEPTH, 4, number of station entries (2..8)
TAG_W, 6, physical-register tag width
ROB_PTR_W, 4, ROB index width (inst_id)
OPC_W, 3, MDU opcode width (mdu_op_* encoding)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
flush  in  1  pipeline flush; clears all entries
disp_req  in  1  dispatch has a valid MDU op
disp_rdy  out  1  station can accept a dispatch this cycle
disp_opc  in  OPC_W  MDU opcode
disp_tag  in  TAG_W  destination physical tag
disp_inst_id  in  ROB_PTR_W  ROB index
disp_src1_rdy / disp_src2_rdy  in  1 each  source value already available
disp_src1 / disp_src2  in  32 each  source value (valid when *_rdy)
disp_src1_tag / disp_src2_tag  in  TAG_W each  producer tag (used when not *_rdy)
cdb_valid  in  1  CDB broadcast valid
cdb_tag  in  TAG_W  broadcast destination tag
cdb_wdata  in  32  broadcast result
iss_req  out  1  a ready entry is presented to the MDU
iss_rdy  in  1  MDU accepts this cycle
iss_opc  out  OPC_W  selected entry opcode
iss_src1 / iss_src2  out  32 each  selected entry operands
iss_tag  out  TAG_W  selected entry destination tag
iss_inst_id  out  ROB_PTR_W  selected entry ROB index

Behaviour:
- Entry state: valid, opc, tag, inst_id, and per source {rdy, tag, data}. Packed entry struct; count register 0..DEPTH.

Reset:
- While rst_n=0, at the clock edge all valid bits and count are cleared.
- Outputs are combinational from state, so after reset disp_rdy=1 and iss_req=0.

Dispatch:
- disp_rdy = (count != DEPTH) & ~flush. No same-cycle credit from an issue.
- A write occurs on disp_req & disp_rdy.
- The new entry goes to position count, or count-1 if an issue happens in the same cycle.

Wakeup:
- cdb_valid & cdb_tag!=0 & cdb_tag==entry.srcN.tag & ~entry.srcN.rdy: set srcN.rdy and capture cdb_wdata at the edge.
- The entry becomes issue-eligible the next cycle; there is no same-cycle CDB-to-issue bypass.
- Dispatch bypass: if disp_srcN_rdy=0 and the CDB matches disp_srcN_tag in the same cycle, the entry is written with rdy=1 and data=cdb_wdata.
- Tag 0 never wakes anything. Dispatch always presents x0 sources as ready with data 0.

Select/issue:
- ready_i = valid_i & src1.rdy & src2.rdy.
- The selected entry is the lowest-index ready entry (the oldest).
- iss_req = |ready & ~flush. iss_* fields are driven combinationally from the selected entry.
- Fields may change cycle to cycle before acceptance, e.g. when an older entry wakes. This is legal because the MDU samples on req&rdy in the same cycle.

Removal:
- On iss_req & iss_rdy, entries above the selected index shift down by one, preserving order, and count decrements.
- Wakeup captures that land on shifting entries must follow the entry to its new index.

Simultaneous events:
- Dispatch, issue and CDB wakeup in one cycle are all honoured; no event is dropped.
- Dispatch into the full station is impossible (disp_rdy=0).

Flush:
- Highest priority. At the edge, all valid bits and count are cleared.
- While flush=1: disp_rdy=0 and iss_req=0. A CDB in the flush cycle is discarded.

Reset mid-operation: all entries are lost with no issue. The MDU is reset by the same rst.

Invariants (assert in bench):
- valid bits are contiguous from index 0.
- popcount(valid) == count.
- iss_req implies the selected entry is valid.

Decomposition:
- rv32i_types package: add rsv_src_t {rdy, tag, data} and mdu_rsv_entry_t {valid, opc, tag, inst_id, src1, src2}. Reuse the existing mdu_op_* encodings.
- Sub-module mdu_rsv_select: a parameterized lowest-index-ready priority encoder returning a one-hot vector and an index.
- Everything else stays inline.

Test Plan:
1. Reset, then dispatch mul with src1=7 and src2=6 both ready, iss_rdy=1 -> iss_req=1 the next cycle with iss_src1=7, iss_src2=6 and the same tag/inst_id; count returns to 0.
2. Dispatch div with src2 waiting on tag 12, then CDB tag=12 data=3 three cycles later -> iss_req=0 until the cycle after the CDB, then iss_src2=3.
3. Dispatch A (waiting on tag 5) then B (ready), iss_rdy=1 -> B issues first; CDB tag 5 -> A issues next with the captured value.
4. Hold iss_rdy=0 and dispatch 4 ready ops -> disp_rdy=0 after the 4th. Raise iss_rdy with a dispatch the same cycle -> issue order is inst_id 0,1,2,3,4 and no entry is lost.
5. Dispatch with src1 tag 9 not ready while CDB tag 9 data=0xDEAD fires the same cycle -> the entry issues next cycle with iss_src1=0xDEAD.
6. With 3 valid entries, assert flush together with disp_req and a CDB -> disp_rdy=0 and iss_req=0 that cycle; count=0 after. A CDB tag 0 broadcast wakes no entry.
